imm_extender: RTL and testbench
===============================

# imm_extender

Registered 16-to-32-bit immediate extender for the CPU datapath. Takes the 16-bit immediate field of an instruction and produces a 32-bit operand, zero-extended or sign-extended under control of `Ctr`. It sits between instruction decode and the ALU operand mux, with one register stage and a valid flag so it can align with a pipelined decode stage.

## Interface
Parameters:
- `IMM_W`, 16, width of the input immediate.
- `RES_W`, 32, width of the extended result; must be greater than `IMM_W`.

Ports:
- `Clk`, input, 1, the single clock; every register updates on its rising edge.
- `Rst_n`, input, 1, asynchronous active-low reset.
- `En`, input, 1, load enable; when low the output register holds its value.
- `InValid`, input, 1, qualifies `Imm` and `Ctr` in the current cycle.
- `Imm`, input, `IMM_W`, immediate field.
- `Ctr`, input, 1, extension mode: 0 = zero-extend, 1 = sign-extend.
- `Res`, output, `RES_W`, registered extended immediate.
- `ResValid`, output, 1, registered copy of `InValid`; marks `Res` as meaningful.

## Operation
- Extension function, E(Imm, Ctr):
  - `Ctr`=0: `{(RES_W-IMM_W){1'b0}, Imm}`.
  - `Ctr`=1: `{(RES_W-IMM_W){Imm[IMM_W-1]}, Imm}`.
- Low `IMM_W` bits of `Res` always equal `Imm`, whatever the mode.
- Upper bits are all 0 (zero mode), or all copies of `Imm[15]` (sign mode).
- On each rising `Clk` with `En`=1:
  - `Res` <= E(`Imm`, `Ctr`).
  - `ResValid` <= `InValid`.
- `Res` is loaded even when `InValid`=0; `Res` is then don't-care and consumers must qualify it with `ResValid`.
- With `En`=0, both `Res` and `ResValid` hold.
- No internal state beyond the output registers; no FSM.
- `Ctr` or `Imm` of X/Z is not supported; behaviour is undefined.

## Timing
- Latency is exactly 1 clock: inputs sampled at edge N appear on `Res` after edge N.
- Throughput is one result per clock while `En`=1.
- Reset (`Rst_n`=0, asynchronous):
  - `Res` = 32'h0000_0000 and `ResValid` = 0 immediately, with no clock needed.
  - Both hold while `Rst_n` is low, regardless of `En` or `InValid`.
- Reset release is synchronous to `Clk`: the first capture is on the first rising edge after `Rst_n` goes high.
- Reset asserted mid-stream discards the in-flight result.
- Toggling `Ctr` with `Imm` held changes `Res` on the next edge only; there is no combinational path from input to output.
- `Ctr` and `Imm` changing in the same cycle are both sampled at the same edge, so no mixed result is produced.

## Test plan
- Reset: drive `Rst_n`=0 asynchronously mid-cycle -> `Res`=0x00000000 and `ResValid`=0 at once; after release plus one edge with `Imm`=0x0fff, `Ctr`=0, `En`=1, `InValid`=1 -> `Res`=0x00000fff, `ResValid`=1.
- Positive immediate: `Imm`=0x0fff held, `Ctr` toggled every 20 ns (`Clk` period 10 ns) -> `Res`=0x00000fff in both modes.
- Negative immediate: `Imm`=0x8001; `Ctr`=0 -> `Res`=0x00008001; `Ctr`=1 -> `Res`=0xffff8001.
- Boundaries:
  - `Imm`=0xffff with `Ctr`=1 -> 0xffffffff; with `Ctr`=0 -> 0x0000ffff.
  - `Imm`=0x7fff with `Ctr`=1 -> 0x00007fff.
  - `Imm`=0x0000 with either mode -> 0x00000000.
- Enable and valid:
  - `En`=0 while `Imm` and `InValid` change -> `Res` and `ResValid` unchanged.
  - `InValid`=0 with `En`=1 -> `ResValid`=0 on the next edge.
- Streaming: back-to-back `Imm` 0x0001, 0xfffe, 0x8000 with `Ctr`=1 -> `Res` sequence 0x00000001, 0xfffffffe, 0xffff8000, one clock behind the inputs.

Source files
------------

// File: rtl/imm_extender.sv
// imm_extender: one-stage registered 16-to-32-bit immediate extender.
// Zero- or sign-extends the instruction immediate under Ctr and registers it
// together with a valid flag so the result lines up with a pipelined decode.
module imm_extender #(
    parameter int unsigned IMM_W = 16,
    parameter int unsigned RES_W = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             En,
    input  logic             InValid,
    input  logic [IMM_W-1:0] Imm,
    input  logic             Ctr,
    output logic [RES_W-1:0] Res,
    output logic             ResValid
);

    // Number of bits filled above the immediate; RES_W must exceed IMM_W.
    localparam int unsigned EXT_W = RES_W - IMM_W;

    logic [RES_W-1:0] res_d;
    logic [RES_W-1:0] res_q;
    logic             valid_d;
    logic             valid_q;
    logic [EXT_W-1:0] fill_c;

    // Fill pattern for the upper bits: copies of the immediate MSB in sign mode.
    always_comb begin
        fill_c = '0;
        if (Ctr) begin
            fill_c = {EXT_W{Imm[IMM_W-1]}};
        end
    end

    // Next-state: load the extended immediate and valid flag when enabled, else hold.
    // Res is loaded even for invalid cycles; ResValid qualifies it downstream.
    always_comb begin
        res_d   = res_q;
        valid_d = valid_q;
        if (En) begin
            res_d   = {fill_c, Imm};
            valid_d = InValid;
        end
    end

    // Output registers with asynchronous clear; reset drops any in-flight result.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    assign Res      = res_q;
    assign ResValid = valid_q;

endmodule

// File: tb/tb_imm_extender.sv
// Self-checking bench for imm_extender: directed spec cases plus random traffic
// compared against an arithmetic reference model.
module tb_imm_extender;

    localparam int unsigned IMM_W = 16;
    localparam int unsigned RES_W = 32;

    logic             Clk;
    logic             Rst_n;
    logic             En;
    logic             InValid;
    logic [IMM_W-1:0] Imm;
    logic             Ctr;
    logic [RES_W-1:0] Res;
    logic             ResValid;

    int unsigned n_checks;
    int unsigned n_errors;

    // Reference state: what Res/ResValid should hold after the last edge.
    logic [RES_W-1:0] exp_res;
    logic             exp_vld;

    imm_extender #(
        .IMM_W(IMM_W),
        .RES_W(RES_W)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .En       (En),
        .InValid  (InValid),
        .Imm      (Imm),
        .Ctr      (Ctr),
        .Res      (Res),
        .ResValid (ResValid)
    );

    // 10 ns clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Extension as arithmetic: the value of Imm read unsigned, or read as a
    // two's-complement number when sign mode is selected.
    function automatic logic [RES_W-1:0] ref_ext(input logic [IMM_W-1:0] imm, input logic ctr);
        int v;
        v = int'(imm);
        if (ctr && v >= 32768) begin
            v = v - 65536;
        end
        return 32'(v);
    endfunction

    task automatic check(input string tag, input logic [RES_W-1:0] got, input logic [RES_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge, update the model from the inputs seen there, then
    // sample outputs 1 ns after the edge.
    task automatic step();
        @(posedge Clk);
        if (Rst_n && En) begin
            exp_res = ref_ext(Imm, Ctr);
            exp_vld = InValid;
        end
        #1;
    endtask

    task automatic drive(input logic [IMM_W-1:0] imm, input logic ctr, input logic en, input logic vld);
        Imm     = imm;
        Ctr     = ctr;
        En      = en;
        InValid = vld;
    endtask

    // Drive one input set, clock it in, and compare against a literal expectation.
    task automatic apply(input string tag, input logic [IMM_W-1:0] imm, input logic ctr,
                         input logic [RES_W-1:0] want);
        drive(imm, ctr, 1'b1, 1'b1);
        step();
        check(tag, Res, want);
        check({tag, "_vld"}, 32'(ResValid), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_res  = '0;
        exp_vld  = 1'b0;
        Rst_n    = 1'b0;
        drive(16'h0000, 1'b0, 1'b0, 1'b0);

        // Reset holds outputs at zero even with enable and valid asserted.
        step();
        drive(16'h1234, 1'b1, 1'b1, 1'b1);
        step();
        check("rst_res", Res, 32'h0000_0000);
        check("rst_vld", 32'(ResValid), 32'd0);

        // Release, then first capture on the following edge.
        Rst_n = 1'b1;
        drive(16'h0fff, 1'b0, 1'b1, 1'b1);
        step();
        check("first_res", Res, 32'h0000_0fff);
        check("first_vld", 32'(ResValid), 32'd1);

        // Positive immediate with Ctr toggled every 20 ns.
        for (int i = 0; i < 4; i++) begin
            apply("pos_a", 16'h0fff, 1'(i % 2), 32'h0000_0fff);
            apply("pos_b", 16'h0fff, 1'(i % 2), 32'h0000_0fff);
        end

        // Negative immediate and boundary values.
        apply("neg_zero", 16'h8001, 1'b0, 32'h0000_8001);
        apply("neg_sign", 16'h8001, 1'b1, 32'hffff_8001);
        apply("ffff_sign", 16'hffff, 1'b1, 32'hffff_ffff);
        apply("ffff_zero", 16'hffff, 1'b0, 32'h0000_ffff);
        apply("7fff_sign", 16'h7fff, 1'b1, 32'h0000_7fff);
        apply("0000_zero", 16'h0000, 1'b0, 32'h0000_0000);
        apply("0000_sign", 16'h0000, 1'b1, 32'h0000_0000);

        // No combinational path: changing Ctr mid-cycle must not move Res.
        apply("comb_pre", 16'h8001, 1'b0, 32'h0000_8001);
        Ctr = 1'b1;
        #2;
        check("comb_hold", Res, 32'h0000_8001);
        step();
        check("comb_next", Res, 32'hffff_8001);

        // En low: outputs hold while Imm and InValid change.
        for (int i = 0; i < 3; i++) begin
            drive(16'(16'h5a5a + i), 1'b1, 1'b0, 1'(i % 2));
            step();
            check("hold_res", Res, 32'hffff_8001);
            check("hold_vld", 32'(ResValid), 32'd1);
        end

        // InValid low with En high clears ResValid on the next edge.
        drive(16'h0042, 1'b0, 1'b1, 1'b0);
        step();
        check("inval_vld", 32'(ResValid), 32'd0);

        // Back-to-back stream in sign mode, one clock behind the inputs.
        apply("strm0", 16'h0001, 1'b1, 32'h0000_0001);
        apply("strm1", 16'hfffe, 1'b1, 32'hffff_fffe);
        apply("strm2", 16'h8000, 1'b1, 32'hffff_8000);

        // Asynchronous reset mid-cycle discards the in-flight result at once.
        drive(16'h9999, 1'b1, 1'b1, 1'b1);
        #2;
        Rst_n   = 1'b0;
        exp_res = '0;
        exp_vld = 1'b0;
        #1;
        check("arst_res", Res, 32'h0000_0000);
        check("arst_vld", 32'(ResValid), 32'd0);
        step();
        check("arst_hold", Res, 32'h0000_0000);
        Rst_n = 1'b1;
        drive(16'hc003, 1'b1, 1'b1, 1'b1);
        step();
        check("arst_rel", Res, 32'hffff_c003);

        // Random traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            drive(16'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
            step();
            check("rnd_res", Res, exp_res);
            check("rnd_vld", 32'(ResValid), 32'(exp_vld));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
